zstr_sink_chk: RTL and testbench

Parametrised, synthesisable successor to the zstr bench sink: consumes a zstr stream (`z_vld`/`z_bus`/`z_ack`), compares each transfer against a queue of expected words, and shapes backpressure. Expected words, masks and per-transfer ack delays are loaded through a second zstr-style port instead of a bench task, so a generator or another FSM can drive it. It sits at the end of zstr pipelines in benches and in on-chip self-test, and exposes pass, error and unexpected counters.

---
 rtl/zstr_pkg.sv | 24 ++
 rtl/zstr_sink_fifo.sv | 86 ++++++++
 rtl/zstr_sink_chk.sv | 170 +++++++++++++++++
 tb/tb_zstr_sink_chk.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zstr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zstr_pkg
//  Description : Shared definitions for the zstr stream sink checker:
//                ack-mode encodings, LFSR tap mask and LFSR step function.
//  Revision    : 1.0  initial release
// ============================================================================
package zstr_pkg;

    // Ack-shaping modes selected by the 2-bit mode input
    localparam logic [1:0] ZSTR_ACK_DELAY  = 2'd0;
    localparam logic [1:0] ZSTR_ACK_ALWAYS = 2'd1;
    localparam logic [1:0] ZSTR_ACK_RANDOM = 2'd2;
    localparam logic [1:0] ZSTR_ACK_STALL  = 2'd3;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] ZSTR_LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] zstr_lfsr_next(input logic [15:0] cur);
        zstr_lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? ZSTR_LFSR_TAPS : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/zstr_sink_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : zstr_sink_fifo
//  Description : Register-array queue of expected entries. Any depth >= 2,
//                pointers wrap explicitly so non power-of-two depths work.
//  Ports       : clk, rst      clock, asynchronous active-high reset
//                i_push/i_data write request (ignored when full)
//                i_pop         pop request (ignored when empty)
//                o_head        entry at the read pointer
//                o_full/o_empty/o_level  occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
module zstr_sink_fifo #(
    parameter int unsigned W  = 8,
    parameter int unsigned LN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(LN+1)-1:0]  o_level
);

    localparam int unsigned          C_PTR_W    = $clog2(LN);
    localparam int unsigned          C_LVL_W    = $clog2(LN + 1);
    localparam logic [C_PTR_W-1:0]   C_PTR_LAST = C_PTR_W'(LN - 1);

    logic [W-1:0]       r_mem_q [LN];
    logic [W-1:0]       w_mem_d [LN];
    logic [C_PTR_W-1:0] r_wpt_q, w_wpt_d;
    logic [C_PTR_W-1:0] r_rpt_q, w_rpt_d;
    logic [C_LVL_W-1:0] r_level_q, w_level_d;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_level_q == C_LVL_W'(LN));
    assign o_empty = (r_level_q == '0);
    assign o_level = r_level_q;
    assign o_head  = r_mem_q[r_rpt_q];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_comb begin
        w_mem_d   = r_mem_q;
        w_wpt_d   = r_wpt_q;
        w_rpt_d   = r_rpt_q;
        w_level_d = r_level_q;
        if (w_push) begin
            w_mem_d[r_wpt_q] = i_data;
            w_wpt_d = (r_wpt_q == C_PTR_LAST) ? '0 : r_wpt_q + C_PTR_W'(1);
        end
        if (w_pop) begin
            w_rpt_d = (r_rpt_q == C_PTR_LAST) ? '0 : r_rpt_q + C_PTR_W'(1);
        end
        // Simultaneous push and pop leaves occupancy unchanged
        case ({w_push, w_pop})
            2'b10:   w_level_d = r_level_q + C_LVL_W'(1);
            2'b01:   w_level_d = r_level_q - C_LVL_W'(1);
            default: w_level_d = r_level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wpt_q   <= '0;
            r_rpt_q   <= '0;
            r_level_q <= '0;
        end else begin
            r_wpt_q   <= w_wpt_d;
            r_rpt_q   <= w_rpt_d;
            r_level_q <= w_level_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides validity
    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/zstr_sink_chk.sv
`default_nettype none
// ============================================================================
//  Module      : zstr_sink_chk
//  Description : zstr stream sink: checks each transfer against a queue of
//                expected {data, mask, delay} entries, shapes z_ack by mode
//                and keeps ok / error / unexpected counters.
//  Ports       : z_clk, z_rst          clock, asynchronous active-high reset
//                e_vld/e_bus/e_msk/e_dly/e_ack  expected-entry load port
//                z_vld/z_bus/z_ack     checked stream
//                mode                  ack mode (delay/always/random/stall)
//                cnt_ok/cnt_err/cnt_unx, err, err_bus, level  status
//  Revision    : 1.0  initial release
// ============================================================================
module zstr_sink_chk
    import zstr_pkg::*;
#(
    parameter int unsigned BW        = 8,
    parameter int unsigned LN        = 4,
    parameter int unsigned DW        = 16,
    parameter int unsigned CW        = 32,
    parameter bit          EMPTY_ACK = 1'b1,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                     z_clk,
    input  logic                     z_rst,
    input  logic                     e_vld,
    input  logic [BW-1:0]            e_bus,
    input  logic [BW-1:0]            e_msk,
    input  logic [DW-1:0]            e_dly,
    output logic                     e_ack,
    input  logic                     z_vld,
    input  logic [BW-1:0]            z_bus,
    output logic                     z_ack,
    input  logic [1:0]               mode,
    output logic [CW-1:0]            cnt_ok,
    output logic [CW-1:0]            cnt_err,
    output logic [CW-1:0]            cnt_unx,
    output logic                     err,
    output logic [BW-1:0]            err_bus,
    output logic [$clog2(LN+1)-1:0]  level
);

    localparam int unsigned C_EW = 2 * BW + DW;

    logic [C_EW-1:0] w_head;
    logic [BW-1:0]   w_head_bus;
    logic [BW-1:0]   w_head_msk;
    logic [DW-1:0]   w_head_dly;
    logic            w_full;
    logic            w_empty;
    logic            w_z_ack;
    logic            w_trn;
    logic            w_mismatch;
    logic            w_flag;

    logic [DW-1:0]   r_dly_q,     w_dly_d;
    logic [15:0]     r_lfsr_q,    w_lfsr_d;
    logic [CW-1:0]   r_cnt_ok_q,  w_cnt_ok_d;
    logic [CW-1:0]   r_cnt_err_q, w_cnt_err_d;
    logic [CW-1:0]   r_cnt_unx_q, w_cnt_unx_d;
    logic            r_err_q,     w_err_d;
    logic [BW-1:0]   r_err_bus_q, w_err_bus_d;

    zstr_sink_fifo #(
        .W  (C_EW),
        .LN (LN)
    ) u_fifo (
        .clk     (z_clk),
        .rst     (z_rst),
        .i_push  (e_vld),
        .i_data  ({e_bus, e_msk, e_dly}),
        .i_pop   (w_trn),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign w_head_bus = w_head[C_EW-1 -: BW];
    assign w_head_msk = w_head[DW +: BW];
    assign w_head_dly = w_head[DW-1:0];

    // Acks depend only on registered state and mode, never on the valids
    always_comb begin
        w_z_ack = 1'b0;
        if (mode == ZSTR_ACK_STALL) begin
            w_z_ack = 1'b0;
        end else if (w_empty) begin
            w_z_ack = EMPTY_ACK;
        end else begin
            case (mode)
                ZSTR_ACK_DELAY:  w_z_ack = (r_dly_q == w_head_dly);
                ZSTR_ACK_ALWAYS: w_z_ack = 1'b1;
                ZSTR_ACK_RANDOM: w_z_ack = r_lfsr_q[0];
                default:         w_z_ack = 1'b0;
            endcase
        end
    end

    assign z_ack      = w_z_ack;
    assign e_ack      = ~w_full;
    assign w_trn      = z_vld & w_z_ack;
    assign w_mismatch = |(w_head_msk & (w_head_bus ^ z_bus));

    always_comb begin
        w_cnt_ok_d  = r_cnt_ok_q;
        w_cnt_err_d = r_cnt_err_q;
        w_cnt_unx_d = r_cnt_unx_q;
        w_err_d     = r_err_q;
        w_err_bus_d = r_err_bus_q;
        w_flag      = 1'b0;
        if (w_trn) begin
            if (!w_empty) begin
                if (w_mismatch) begin
                    w_cnt_err_d = r_cnt_err_q + CW'(1);
                    w_flag      = 1'b1;
                end else begin
                    w_cnt_ok_d  = r_cnt_ok_q + CW'(1);
                end
            end else begin
                w_cnt_unx_d = r_cnt_unx_q + CW'(1);
                w_flag      = 1'b1;
            end
        end
        // Only the first error is captured; later ones leave err_bus alone
        if (w_flag && !r_err_q) begin
            w_err_d     = 1'b1;
            w_err_bus_d = z_bus;
        end

        // Delay counter measures how long the current word has waited
        if (w_trn || !z_vld) begin
            w_dly_d = '0;
        end else if (r_dly_q != {DW{1'b1}}) begin
            w_dly_d = r_dly_q + DW'(1);
        end else begin
            w_dly_d = r_dly_q;
        end

        w_lfsr_d = zstr_lfsr_next(r_lfsr_q);
    end

    always_ff @(posedge z_clk or posedge z_rst) begin
        if (z_rst) begin
            r_dly_q     <= '0;
            r_lfsr_q    <= SEED;
            r_cnt_ok_q  <= '0;
            r_cnt_err_q <= '0;
            r_cnt_unx_q <= '0;
            r_err_q     <= 1'b0;
            r_err_bus_q <= '0;
        end else begin
            r_dly_q     <= w_dly_d;
            r_lfsr_q    <= w_lfsr_d;
            r_cnt_ok_q  <= w_cnt_ok_d;
            r_cnt_err_q <= w_cnt_err_d;
            r_cnt_unx_q <= w_cnt_unx_d;
            r_err_q     <= w_err_d;
            r_err_bus_q <= w_err_bus_d;
        end
    end

    assign cnt_ok  = r_cnt_ok_q;
    assign cnt_err = r_cnt_err_q;
    assign cnt_unx = r_cnt_unx_q;
    assign err     = r_err_q;
    assign err_bus = r_err_bus_q;

endmodule
`default_nettype wire

// File: tb/tb_zstr_sink_chk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zstr_sink_chk
//  Description : Self-checking bench for zstr_sink_chk. Instance A uses the
//                default parameters (LN=4, EMPTY_ACK=1); instance B uses
//                LN=3, EMPTY_ACK=0 for full-queue and held-ack sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_zstr_sink_chk;

    localparam int unsigned LN_A = 4;
    localparam int unsigned LN_B = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // Instance A
    logic        a_e_vld = 0, a_e_ack, a_z_vld = 0, a_z_ack, a_err;
    logic [7:0]  a_e_bus = 0, a_e_msk = 0, a_z_bus = 0, a_err_bus;
    logic [15:0] a_e_dly = 0;
    logic [1:0]  a_mode = 0;
    logic [31:0] a_cnt_ok, a_cnt_err, a_cnt_unx;
    logic [2:0]  a_level;

    // Instance B
    logic        b_e_vld = 0, b_e_ack, b_z_vld = 0, b_z_ack, b_err;
    logic [7:0]  b_e_bus = 0, b_e_msk = 0, b_z_bus = 0, b_err_bus;
    logic [15:0] b_e_dly = 0;
    logic [1:0]  b_mode = 0;
    logic [31:0] b_cnt_ok, b_cnt_err, b_cnt_unx;
    logic [1:0]  b_level;

    zstr_sink_chk #(.BW(8), .LN(LN_A), .DW(16), .CW(32), .EMPTY_ACK(1'b1), .SEED(SEED)) u_dut_a (
        .z_clk(clk), .z_rst(rst),
        .e_vld(a_e_vld), .e_bus(a_e_bus), .e_msk(a_e_msk), .e_dly(a_e_dly), .e_ack(a_e_ack),
        .z_vld(a_z_vld), .z_bus(a_z_bus), .z_ack(a_z_ack), .mode(a_mode),
        .cnt_ok(a_cnt_ok), .cnt_err(a_cnt_err), .cnt_unx(a_cnt_unx),
        .err(a_err), .err_bus(a_err_bus), .level(a_level)
    );

    zstr_sink_chk #(.BW(8), .LN(LN_B), .DW(16), .CW(32), .EMPTY_ACK(1'b0), .SEED(SEED)) u_dut_b (
        .z_clk(clk), .z_rst(rst),
        .e_vld(b_e_vld), .e_bus(b_e_bus), .e_msk(b_e_msk), .e_dly(b_e_dly), .e_ack(b_e_ack),
        .z_vld(b_z_vld), .z_bus(b_z_bus), .z_ack(b_z_ack), .mode(b_mode),
        .cnt_ok(b_cnt_ok), .cnt_err(b_cnt_err), .cnt_unx(b_cnt_unx),
        .err(b_err), .err_bus(b_err_bus), .level(b_level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic        e_vld;
        logic [7:0]  e_bus;
        logic [7:0]  e_msk;
        logic [15:0] e_dly;
        logic        z_vld;
        logic [7:0]  z_bus;
        logic        x_z_ack;
        logic [2:0]  x_level;
        logic [31:0] x_ok;
        logic [31:0] x_err;
        logic        x_errf;
        logic [7:0]  x_err_bus;
    } vec_t;

    vec_t tbl [10];

    // ---------------- reference model (instance A) ----------------
    typedef struct packed {
        logic [7:0]  bus;
        logic [7:0]  msk;
        logic [15:0] dly;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_ok, m_err, m_unx, m_wait;
    logic        m_errf;
    logic [7:0]  m_errbus;
    logic [15:0] m_lfsr;

    task automatic model_reset();
        mq.delete();
        m_ok = 0; m_err = 0; m_unx = 0; m_wait = 0;
        m_errf = 1'b0; m_errbus = 8'h00; m_lfsr = SEED;
    endtask

    // One cycle: inputs already set at posedge+1; check, advance model, clock.
    task automatic model_step(output logic trn);
        logic za, ea, bad, empty;
        ent_t h;
        #1;
        empty = (mq.size() == 0);
        if (a_mode == 2'd3)      za = 1'b0;
        else if (empty)          za = 1'b1;
        else if (a_mode == 2'd0) za = (m_wait == 32'(mq[0].dly));
        else if (a_mode == 2'd1) za = 1'b1;
        else                     za = m_lfsr[0];
        ea = (mq.size() < LN_A);
        check("m_z_ack",   a_z_ack,   za);
        check("m_e_ack",   a_e_ack,   ea);
        check("m_level",   a_level,   mq.size());
        check("m_cnt_ok",  a_cnt_ok,  m_ok);
        check("m_cnt_err", a_cnt_err, m_err);
        check("m_cnt_unx", a_cnt_unx, m_unx);
        check("m_err",     a_err,     m_errf);
        check("m_err_bus", a_err_bus, m_errbus);
        trn = a_z_vld & za;
        bad = 1'b0;
        if (trn) begin
            if (!empty) begin
                h = mq.pop_front();
                if ((h.msk & (h.bus ^ a_z_bus)) != 8'h00) begin m_err++; bad = 1'b1; end
                else m_ok++;
            end else begin
                m_unx++;
                bad = 1'b1;
            end
            if (bad && !m_errf) begin m_errf = 1'b1; m_errbus = a_z_bus; end
        end
        if (trn || !a_z_vld)   m_wait = 0;
        else if (m_wait < 65535) m_wait++;
        if (a_e_vld && ea) mq.push_back('{a_e_bus, a_e_msk, a_e_dly});
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic        t;
    int unsigned xfers;

    initial begin
        // fields: e_vld bus msk dly | z_vld bus | z_ack level ok err errf err_bus
        tbl[0] = '{1'b1, 8'hA5, 8'hFF, 16'd0, 1'b0, 8'h00, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'h3C, 8'hF0, 16'd2, 1'b1, 8'hA5, 1'b1, 3'd1, 32'd0, 32'd0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 8'h00, 8'h00, 16'd0, 1'b1, 8'h35, 1'b0, 3'd1, 32'd1, 32'd0, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 8'h00, 8'h00, 16'd0, 1'b1, 8'h35, 1'b0, 3'd1, 32'd1, 32'd0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 8'h00, 8'h00, 16'd0, 1'b1, 8'h35, 1'b1, 3'd1, 32'd1, 32'd0, 1'b0, 8'h00};
        tbl[5] = '{1'b1, 8'h55, 8'hFF, 16'd0, 1'b0, 8'h00, 1'b1, 3'd0, 32'd2, 32'd0, 1'b0, 8'h00};
        tbl[6] = '{1'b0, 8'h00, 8'h00, 16'd0, 1'b1, 8'h54, 1'b1, 3'd1, 32'd2, 32'd0, 1'b0, 8'h00};
        tbl[7] = '{1'b1, 8'h77, 8'h0F, 16'd0, 1'b0, 8'h00, 1'b1, 3'd0, 32'd2, 32'd1, 1'b1, 8'h54};
        tbl[8] = '{1'b0, 8'h00, 8'h00, 16'd0, 1'b1, 8'h87, 1'b1, 3'd1, 32'd2, 32'd1, 1'b1, 8'h54};
        tbl[9] = '{1'b0, 8'h00, 8'h00, 16'd0, 1'b0, 8'h00, 1'b1, 3'd0, 32'd3, 32'd1, 1'b1, 8'h54};

        // ---- reset values ----
        do_reset();
        #1;
        check("rst_z_ack",  a_z_ack,  1'b1);
        check("rst_e_ack",  a_e_ack,  1'b1);
        check("rst_level",  a_level,  3'd0);
        check("rst_cnt_ok", a_cnt_ok, 32'd0);
        check("rst_err",    a_err,    1'b0);
        check("rst_b_zack", b_z_ack,  1'b0);

        // ---- table: delay mode, compare, sticky error ----
        a_mode = 2'd0;
        for (int i = 0; i < 10; i++) begin
            a_e_vld = tbl[i].e_vld; a_e_bus = tbl[i].e_bus;
            a_e_msk = tbl[i].e_msk; a_e_dly = tbl[i].e_dly;
            a_z_vld = tbl[i].z_vld; a_z_bus = tbl[i].z_bus;
            #1;
            check($sformatf("tbl%0d_z_ack", i),   a_z_ack,   tbl[i].x_z_ack);
            check($sformatf("tbl%0d_e_ack", i),   a_e_ack,   tbl[i].x_level != 3'd4);
            check($sformatf("tbl%0d_level", i),   a_level,   tbl[i].x_level);
            check($sformatf("tbl%0d_cnt_ok", i),  a_cnt_ok,  tbl[i].x_ok);
            check($sformatf("tbl%0d_cnt_err", i), a_cnt_err, tbl[i].x_err);
            check($sformatf("tbl%0d_err", i),     a_err,     tbl[i].x_errf);
            check($sformatf("tbl%0d_err_bus", i), a_err_bus, tbl[i].x_err_bus);
            step();
        end
        a_e_vld = 0; a_z_vld = 0;

        // ---- A: unexpected transfers on an empty queue ----
        do_reset();
        a_mode = 2'd3;
        #1;
        check("stall_empty_z_ack", a_z_ack, 1'b0);
        a_mode = 2'd0;
        a_z_vld = 1'b1; a_z_bus = 8'h11;
        step();
        a_z_bus = 8'h22;
        step();
        a_z_vld = 1'b0;
        #1;
        check("unx_cnt",     a_cnt_unx, 32'd2);
        check("unx_err",     a_err,     1'b1);
        check("unx_err_bus", a_err_bus, 8'h11);
        check("unx_cnt_ok",  a_cnt_ok,  32'd0);

        // ---- B: EMPTY_ACK=0 holds ack low until first load ----
        b_mode = 2'd1; b_z_vld = 1'b1; b_z_bus = 8'h10;
        #1;
        check("b_empty_z_ack0", b_z_ack, 1'b0);
        step();
        check("b_empty_z_ack1", b_z_ack, 1'b0);
        b_e_vld = 1'b1; b_e_bus = 8'h10; b_e_msk = 8'hFF; b_e_dly = 16'd0;
        #1;
        check("b_load_no_comb", b_z_ack, 1'b0);
        step();
        b_e_vld = 1'b0;
        #1;
        check("b_ack_after_load", b_z_ack, 1'b1);
        step();
        b_z_vld = 1'b0;
        #1;
        check("b_ok1",  b_cnt_ok,  32'd1);
        check("b_unx0", b_cnt_unx, 32'd0);
        check("b_lvl0", b_level,   2'd0);

        // ---- B: fill to LN=3, pop while full, wrap ----
        b_e_vld = 1'b1; b_e_msk = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            b_e_bus = 8'h21 + 8'(i);
            step();
        end
        b_e_bus = 8'h24;
        #1;
        check("b_full_e_ack", b_e_ack, 1'b0);
        check("b_full_level", b_level, 2'd3);
        b_z_vld = 1'b1; b_z_bus = 8'h21;
        step();
        b_z_vld = 1'b0;
        #1;
        check("b_pop_full_level", b_level, 2'd2);
        check("b_pop_full_e_ack", b_e_ack, 1'b1);
        check("b_pop_full_ok",    b_cnt_ok, 32'd2);
        step();
        b_e_vld = 1'b0;
        #1;
        check("b_refill_level", b_level, 2'd3);
        b_z_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_z_bus = 8'h22 + 8'(i);
            step();
        end
        b_z_vld = 1'b0;
        #1;
        check("b_drain_ok",    b_cnt_ok,  32'd5);
        check("b_drain_err",   b_cnt_err, 32'd0);
        check("b_drain_level", b_level,   2'd0);

        // ---- A: RANDOM mode, 100 matching delay-0 entries ----
        a_e_vld = 0; a_z_vld = 0; a_mode = 2'd2;
        do_reset();
        model_reset();
        xfers = 0;
        for (int c = 0; c < 1500 && xfers < 100; c++) begin
            a_e_vld = (mq.size() < LN_A);
            a_e_bus = 8'($urandom); a_e_msk = 8'hFF; a_e_dly = 16'd0;
            a_z_vld = (mq.size() != 0);
            a_z_bus = 8'h00;
            if (mq.size() != 0) a_z_bus = mq[0].bus;
            model_step(t);
            if (t) xfers++;
        end
        check("rand_xfers",   xfers,     32'd100);
        check("rand_cnt_ok",  a_cnt_ok,  32'd100);
        check("rand_cnt_err", a_cnt_err, 32'd0);

        // ---- A: switch to STALL mid-stream ----
        a_mode = 2'd3;
        for (int c = 0; c < 12; c++) begin
            a_e_vld = 1'($urandom); a_e_bus = 8'($urandom);
            a_z_vld = 1'b1;
            if (mq.size() != 0) a_z_bus = mq[0].bus;
            model_step(t);
        end
        check("stall_cnt_ok", a_cnt_ok, 32'd100);

        // ---- A: mixed random traffic, modes, masks, delays ----
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 15) == 0) a_mode = 2'($urandom_range(0, 3));
            a_e_vld = 1'($urandom);
            a_e_bus = 8'($urandom); a_e_msk = 8'($urandom);
            a_e_dly = 16'($urandom_range(0, 3));
            a_z_vld = ($urandom_range(0, 3) != 0);
            if (mq.size() != 0 && $urandom_range(0, 7) != 0)
                a_z_bus = mq[0].bus ^ (~mq[0].msk & 8'($urandom));
            else
                a_z_bus = 8'($urandom);
            model_step(t);
        end

        // ---- A: asynchronous reset with a non-empty queue ----
        a_mode = 2'd1; a_z_vld = 1'b0; a_e_vld = 1'b1;
        model_step(t);
        model_step(t);
        rst = 1'b1;
        #1;
        check("arst_level",  a_level,  3'd0);
        check("arst_z_ack",  a_z_ack,  1'b1);
        check("arst_cnt_ok", a_cnt_ok, 32'd0);
        check("arst_err",    a_err,    1'b0);
        a_mode = 2'd3;
        #1;
        check("arst_stall_z_ack", a_z_ack, 1'b0);
        step();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
